tl_a_channel_arbiter: RTL and testbench

- Shares the single 53-bit A channel and 43-bit D channel of the data-memory slave between two masters: m0 (instruction fetch) and m1 (load/store master).
- Arbitrates A-channel requests round-robin and stamps each request's source field with the master index.
- Holds one outstanding transaction per master.
- Routes each D-channel response back to the master whose index matches the response source field.

---
 rtl/tl_pkg.sv | 49 ++++
 rtl/tl_a_channel_arbiter_if.sv | 52 +++++
 rtl/tl_a_channel_arbiter_rr_arb2.sv | 14 +
 rtl/tl_a_channel_arbiter.sv | 131 +++++++++++++
 tb/tb_tl_a_channel_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tl_pkg.sv
// Shared TileLink-style field positions, opcodes and FSM state for the A/D channel arbiter.
package tl_pkg;

  localparam int A_W   = 53;
  localparam int D_W   = 43;
  localparam int NUM_M = 2;

  // A-channel field positions
  localparam int A_OPC_HI   = 52;
  localparam int A_OPC_LO   = 50;
  localparam int A_PARAM_HI = 49;
  localparam int A_PARAM_LO = 47;
  localparam int A_SIZE_HI  = 46;
  localparam int A_SIZE_LO  = 44;
  localparam int A_SRC_HI   = 43;
  localparam int A_SRC_LO   = 42;
  localparam int A_ADDR_HI  = 41;
  localparam int A_ADDR_LO  = 32;
  localparam int A_DATA_HI  = 31;
  localparam int A_DATA_LO  = 0;

  // D-channel field positions
  localparam int D_OPC_HI   = 42;
  localparam int D_OPC_LO   = 40;
  localparam int D_PARAM_HI = 39;
  localparam int D_PARAM_LO = 37;
  localparam int D_SIZE_HI  = 36;
  localparam int D_SIZE_LO  = 34;
  localparam int D_SRC_HI   = 33;
  localparam int D_SRC_LO   = 32;
  localparam int D_DATA_HI  = 31;
  localparam int D_DATA_LO  = 0;

  localparam logic [2:0] OPC_GET      = 3'd4;
  localparam logic [2:0] OPC_PUT_FULL = 3'd0;
  localparam logic [2:0] OPC_ACK      = 3'd0;
  localparam logic [2:0] OPC_ACK_DATA = 3'd1;

  typedef enum logic {IDLE, ISSUE} arb_state_e;

  // Replace the source field of an A-channel beat, leaving every other bit untouched.
  function automatic logic [A_W-1:0] stamp_source(input logic [A_W-1:0] a, input logic [1:0] src);
    logic [A_W-1:0] r;
    r = a;
    r[A_SRC_HI:A_SRC_LO] = src;
    return r;
  endfunction

endpackage

// File: rtl/tl_a_channel_arbiter_if.sv
// Bundle of both master ports, the slave port and the status flag of the arbiter.
// 'slave' is the arbiter's view (it serves the two masters); 'master' is the surrounding environment.
interface tl_a_channel_arbiter_if;
  import tl_pkg::*;

  logic           m0_a_valid;
  logic [A_W-1:0] m0_a_channel;
  logic           m0_a_ready;
  logic           m0_d_valid;
  logic [D_W-1:0] m0_d_channel;
  logic           m0_d_error;

  logic           m1_a_valid;
  logic [A_W-1:0] m1_a_channel;
  logic           m1_a_ready;
  logic           m1_d_valid;
  logic [D_W-1:0] m1_d_channel;
  logic           m1_d_error;

  logic           backpressureslave;
  logic           s_a_valid;
  logic [A_W-1:0] s_a_channel;
  logic           s_a_ready;
  logic           s_d_valid;
  logic [D_W-1:0] s_d_channel;
  logic           s_d_error;
  logic           s_d_ready;
  logic           protocol_err;

  modport slave (
    input  m0_a_valid, m0_a_channel,
    output m0_a_ready, m0_d_valid, m0_d_channel, m0_d_error,
    input  m1_a_valid, m1_a_channel,
    output m1_a_ready, m1_d_valid, m1_d_channel, m1_d_error,
    input  backpressureslave,
    output s_a_valid, s_a_channel,
    input  s_a_ready, s_d_valid, s_d_channel, s_d_error,
    output s_d_ready, protocol_err
  );

  modport master (
    output m0_a_valid, m0_a_channel,
    input  m0_a_ready, m0_d_valid, m0_d_channel, m0_d_error,
    output m1_a_valid, m1_a_channel,
    input  m1_a_ready, m1_d_valid, m1_d_channel, m1_d_error,
    output backpressureslave,
    input  s_a_valid, s_a_channel,
    output s_a_ready, s_d_valid, s_d_channel, s_d_error,
    input  s_d_ready, protocol_err
  );

endinterface

// File: rtl/tl_a_channel_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: on a tie the master that did not win last time is chosen.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  // One-hot grant; a single requester always wins outright.
  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) grant_o = last_grant_i ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/tl_a_channel_arbiter.sv
// Shares one A/D channel pair of the data-memory slave between instruction fetch (m0)
// and load/store (m1); one outstanding transaction per master, responses routed by source.
//
// state | meaning
// IDLE  | no request on the slave A channel; a grant may be made this cycle
// ISSUE | request held on the slave A channel until s_a_ready
module tl_a_channel_arbiter
  import tl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  tl_a_channel_arbiter_if.slave  bus
);

  arb_state_e                     state_q, state_d;
  logic                           last_grant_q, last_grant_d;
  logic [NUM_M-1:0]               busy_q, busy_d, set_busy, clr_busy;
  logic                           s_a_valid_q, s_a_valid_d;
  logic [A_W-1:0]                 s_a_channel_q, s_a_channel_d;
  logic [NUM_M-1:0]               md_valid_q, md_valid_d;
  logic [NUM_M-1:0][D_W-1:0]      md_channel_q, md_channel_d;
  logic [NUM_M-1:0]               md_error_q, md_error_d;
  logic                           protocol_err_q, protocol_err_d;

  logic [1:0] eligible, grant, grant_fire;
  logic [1:0] rsp_src;

  assign eligible   = {bus.m1_a_valid & ~busy_q[1], bus.m0_a_valid & ~busy_q[0]}
                      & {2{~bus.backpressureslave}};
  assign grant_fire = (state_q == IDLE) ? grant : 2'b00;
  assign rsp_src    = bus.s_d_channel[D_SRC_HI:D_SRC_LO];

  rr_arb2 u_rr_arb2 (
    .req_i       (eligible),
    .last_grant_i(last_grant_q),
    .grant_o     (grant)
  );

  // Grant/issue FSM: capture the winning request with its source stamped, hold it until accepted.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    s_a_valid_d   = s_a_valid_q;
    s_a_channel_d = s_a_channel_q;
    set_busy      = '0;
    case (state_q)
      IDLE: begin
        if (grant_fire[0]) begin
          s_a_channel_d = stamp_source(bus.m0_a_channel, 2'd0);
          s_a_valid_d   = 1'b1;
          last_grant_d  = 1'b0;
          set_busy[0]   = 1'b1;
          state_d       = ISSUE;
        end else if (grant_fire[1]) begin
          s_a_channel_d = stamp_source(bus.m1_a_channel, 2'd1);
          s_a_valid_d   = 1'b1;
          last_grant_d  = 1'b1;
          set_busy[1]   = 1'b1;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.s_a_ready) begin
          s_a_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Response routing: deliver to the busy master named by the source field, otherwise flag it.
  always_comb begin
    md_valid_d     = '0;
    md_channel_d   = md_channel_q;
    md_error_d     = md_error_q;
    clr_busy       = '0;
    protocol_err_d = protocol_err_q;
    if (bus.s_d_valid) begin
      if (!rsp_src[1] && busy_q[rsp_src[0]]) begin
        md_valid_d[rsp_src[0]]   = 1'b1;
        md_channel_d[rsp_src[0]] = bus.s_d_channel;
        md_error_d[rsp_src[0]]   = bus.s_d_error;
        clr_busy[rsp_src[0]]     = 1'b1;
      end else begin
        protocol_err_d = 1'b1;
      end
    end
    // A grant only targets a non-busy master and a clear only a busy one, so they never collide.
    busy_d = (busy_q & ~clr_busy) | set_busy;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      last_grant_q   <= 1'b1;
      busy_q         <= '0;
      s_a_valid_q    <= 1'b0;
      s_a_channel_q  <= '0;
      md_valid_q     <= '0;
      md_channel_q   <= '0;
      md_error_q     <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      busy_q         <= busy_d;
      s_a_valid_q    <= s_a_valid_d;
      s_a_channel_q  <= s_a_channel_d;
      md_valid_q     <= md_valid_d;
      md_channel_q   <= md_channel_d;
      md_error_q     <= md_error_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  assign bus.m0_a_ready   = grant_fire[0];
  assign bus.m1_a_ready   = grant_fire[1];
  assign bus.m0_d_valid   = md_valid_q[0];
  assign bus.m1_d_valid   = md_valid_q[1];
  assign bus.m0_d_channel = md_channel_q[0];
  assign bus.m1_d_channel = md_channel_q[1];
  assign bus.m0_d_error   = md_error_q[0];
  assign bus.m1_d_error   = md_error_q[1];
  assign bus.s_a_valid    = s_a_valid_q;
  assign bus.s_a_channel  = s_a_channel_q;
  assign bus.s_d_ready    = ~reset;
  assign bus.protocol_err = protocol_err_q;

endmodule

// File: tb/tb_tl_a_channel_arbiter.sv
// Scoreboard bench for the two-master A/D channel arbiter.
module tb_tl_a_channel_arbiter;
  import tl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tl_a_channel_arbiter_if bus();

  tl_a_channel_arbiter dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [D_W-1:0] ch;
    logic           err;
  } d_exp_t;

  int errors = 0;
  int checks = 0;

  logic [A_W-1:0] exp_a[$];
  d_exp_t         exp_d0[$];
  d_exp_t         exp_d1[$];

  function automatic logic [A_W-1:0] mk_a(input logic [2:0] opc, input logic [2:0] size,
                                          input logic [1:0] src, input logic [9:0] addr,
                                          input logic [31:0] data);
    return {opc, 3'd0, size, src, addr, data};
  endfunction

  function automatic logic [D_W-1:0] mk_d(input logic [2:0] opc, input logic [2:0] size,
                                          input logic [1:0] src, input logic [31:0] data);
    return {opc, 3'd0, size, src, data};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.m0_a_valid        = 1'b0;
    bus.m0_a_channel      = '0;
    bus.m1_a_valid        = 1'b0;
    bus.m1_a_channel      = '0;
    bus.backpressureslave = 1'b0;
    bus.s_a_ready         = 1'b0;
    bus.s_d_valid         = 1'b0;
    bus.s_d_channel       = '0;
    bus.s_d_error         = 1'b0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    clear_inputs();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // Waits (bounded) for mN_a_ready; returns at the drive point after the granting edge.
  task automatic wait_grant(input int m, input int limit, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if ((m == 0 && bus.m0_a_ready) || (m == 1 && bus.m1_a_ready)) begin
        cyc();
        return;
      end
      if (n >= limit) begin
        checks++;
        errors++;
        $display("FAIL grant_timeout_m%0d: got no ready, expected ready within %0d cycles", m, limit);
        cyc();
        return;
      end
      cyc();
      n++;
    end
  endtask

  // Monitor: pops the expected beat whenever the DUT presents one.
  always @(negedge clk) begin : monitor
    logic [A_W-1:0] ea;
    d_exp_t         ed;
    if (!reset) begin
      if (bus.s_a_valid && bus.s_a_ready) begin
        if (exp_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL s_a_unexpected: got %0h, expected no request", bus.s_a_channel);
        end else begin
          ea = exp_a.pop_front();
          chk("s_a_channel", bus.s_a_channel, ea);
        end
      end
      if (bus.m0_d_valid) begin
        if (exp_d0.size() == 0) begin
          checks++; errors++;
          $display("FAIL m0_d_unexpected: got %0h, expected no response", bus.m0_d_channel);
        end else begin
          ed = exp_d0.pop_front();
          chk("m0_d_channel", bus.m0_d_channel, ed.ch);
          chk("m0_d_error", bus.m0_d_error, ed.err);
        end
      end
      if (bus.m1_d_valid) begin
        if (exp_d1.size() == 0) begin
          checks++; errors++;
          $display("FAIL m1_d_unexpected: got %0h, expected no response", bus.m1_d_channel);
        end else begin
          ed = exp_d1.pop_front();
          chk("m1_d_channel", bus.m1_d_channel, ed.ch);
          chk("m1_d_error", bus.m1_d_error, ed.err);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [A_W-1:0] a0, a1, b0, c0, e0;
    logic [D_W-1:0] d;
    int n;

    clear_inputs();
    reset = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_s_a_valid", bus.s_a_valid, 0);
    chk("rst_s_a_channel", bus.s_a_channel, 0);
    chk("rst_m0_d_valid", bus.m0_d_valid, 0);
    chk("rst_m1_d_valid", bus.m1_d_valid, 0);
    chk("rst_m0_d_channel", bus.m0_d_channel, 0);
    chk("rst_m1_d_error", bus.m1_d_error, 0);
    chk("rst_protocol_err", bus.protocol_err, 0);
    chk("rst_s_d_ready", bus.s_d_ready, 0);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("s_d_ready_run", bus.s_d_ready, 1);
    cyc();

    // Single m1 GET; incoming source bits set to 3 must be overwritten with 1.
    bus.m1_a_channel = mk_a(OPC_GET, 3'd2, 2'd3, 10'h01C, 32'h0);
    bus.m1_a_valid   = 1'b1;
    bus.s_a_ready    = 1'b1;
    exp_a.push_back(mk_a(OPC_GET, 3'd2, 2'd1, 10'h01C, 32'h0));
    @(negedge clk);
    chk("t1_m1_ready_c0", bus.m1_a_ready, 1);
    chk("t1_m0_ready_c0", bus.m0_a_ready, 0);
    cyc();
    bus.m1_a_valid = 1'b0;
    @(negedge clk);
    chk("t1_s_a_valid_c1", bus.s_a_valid, 1);
    cyc();
    @(negedge clk);
    chk("t1_s_a_valid_c2", bus.s_a_valid, 0);
    cyc();
    cyc();
    d = mk_d(OPC_ACK_DATA, 3'd2, 2'd1, 32'hDEADBEEF);
    bus.s_d_valid   = 1'b1;
    bus.s_d_channel = d;
    exp_d1.push_back('{ch: d, err: 1'b0});
    @(negedge clk);
    chk("t1_m1_d_valid_c4", bus.m1_d_valid, 0);
    cyc();
    bus.s_d_valid = 1'b0;
    @(negedge clk);
    chk("t1_m1_d_valid_c5", bus.m1_d_valid, 1);
    cyc();
    @(negedge clk);
    chk("t1_m1_d_valid_c6", bus.m1_d_valid, 0);
    cyc();

    // Both masters requesting from reset: m0, m1, then m0 again only after its response.
    reset_dut();
    a0 = mk_a(OPC_PUT_FULL, 3'd2, 2'd0, 10'h100, 32'h11111111);
    a1 = mk_a(OPC_PUT_FULL, 3'd2, 2'd0, 10'h104, 32'h22222222);
    b0 = mk_a(OPC_GET,      3'd2, 2'd0, 10'h200, 32'h0);
    bus.m0_a_channel = a0;
    bus.m0_a_valid   = 1'b1;
    bus.m1_a_channel = b0;
    bus.m1_a_valid   = 1'b1;
    bus.s_a_ready    = 1'b1;
    exp_a.push_back(mk_a(OPC_PUT_FULL, 3'd2, 2'd0, 10'h100, 32'h11111111));
    exp_a.push_back(mk_a(OPC_GET,      3'd2, 2'd1, 10'h200, 32'h0));
    exp_a.push_back(mk_a(OPC_PUT_FULL, 3'd2, 2'd0, 10'h104, 32'h22222222));
    wait_grant(0, 4, n);
    chk("t2_m0_first_wait", n, 0);
    bus.m0_a_channel = a1;
    wait_grant(1, 4, n);
    chk("t2_m1_second_wait", n, 1);
    bus.m1_a_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_m0_withheld", bus.m0_a_ready, 0);
      cyc();
    end
    d = mk_d(OPC_ACK, 3'd2, 2'd0, 32'h0);
    bus.s_d_valid   = 1'b1;
    bus.s_d_channel = d;
    exp_d0.push_back('{ch: d, err: 1'b0});
    @(negedge clk);
    chk("t2_m0_rsp_cycle_no_grant", bus.m0_a_ready, 0);
    cyc();
    bus.s_d_valid = 1'b0;
    @(negedge clk);
    chk("t2_m0_regrant", bus.m0_a_ready, 1);
    cyc();
    bus.m0_a_valid = 1'b0;
    cyc();
    d = mk_d(OPC_ACK_DATA, 3'd2, 2'd1, 32'hCAFE0001);
    bus.s_d_valid   = 1'b1;
    bus.s_d_channel = d;
    exp_d1.push_back('{ch: d, err: 1'b0});
    cyc();
    d = mk_d(OPC_ACK, 3'd2, 2'd0, 32'h0);
    bus.s_d_channel = d;
    exp_d0.push_back('{ch: d, err: 1'b0});
    cyc();
    bus.s_d_valid = 1'b0;
    cyc();

    // Backpressure blocks grants; then slave stalls acceptance for 3 cycles in ISSUE.
    c0 = mk_a(OPC_GET, 3'd1, 2'd2, 10'h3FF, 32'h0);
    bus.backpressureslave = 1'b1;
    bus.m0_a_channel      = c0;
    bus.m0_a_valid        = 1'b1;
    bus.s_a_ready         = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_bp_m0_ready", bus.m0_a_ready, 0);
      chk("t3_bp_s_a_valid", bus.s_a_valid, 0);
      cyc();
    end
    bus.backpressureslave = 1'b0;
    exp_a.push_back(mk_a(OPC_GET, 3'd1, 2'd0, 10'h3FF, 32'h0));
    @(negedge clk);
    chk("t3_grant_after_bp", bus.m0_a_ready, 1);
    cyc();
    bus.m0_a_valid        = 1'b0;
    bus.backpressureslave = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", bus.s_a_valid, 1);
      chk("t4_hold_channel", bus.s_a_channel, mk_a(OPC_GET, 3'd1, 2'd0, 10'h3FF, 32'h0));
      cyc();
    end
    bus.s_a_ready = 1'b1;
    cyc();
    bus.backpressureslave = 1'b0;
    @(negedge clk);
    chk("t4_valid_dropped", bus.s_a_valid, 0);
    cyc();
    d = mk_d(OPC_ACK_DATA, 3'd1, 2'd0, 32'h0BADF00D);
    bus.s_d_valid   = 1'b1;
    bus.s_d_channel = d;
    exp_d0.push_back('{ch: d, err: 1'b0});
    cyc();
    bus.s_d_valid = 1'b0;
    cyc();

    // Unexpected responses: source 0 while idle, then source 3.
    bus.s_d_valid   = 1'b1;
    bus.s_d_channel = mk_d(OPC_ACK, 3'd2, 2'd0, 32'h0);
    @(negedge clk);
    chk("t5_perr_before", bus.protocol_err, 0);
    cyc();
    bus.s_d_channel = mk_d(OPC_ACK, 3'd2, 2'd3, 32'h0);
    @(negedge clk);
    chk("t5_perr_src0", bus.protocol_err, 1);
    chk("t5_no_m0_d_valid", bus.m0_d_valid, 0);
    cyc();
    bus.s_d_valid = 1'b0;
    @(negedge clk);
    chk("t5_no_d_valid_src3", {bus.m1_d_valid, bus.m0_d_valid}, 0);
    cyc();
    cyc();
    @(negedge clk);
    chk("t5_perr_sticky", bus.protocol_err, 1);
    cyc();
    reset_dut();
    @(negedge clk);
    chk("t5_perr_after_reset", bus.protocol_err, 0);
    cyc();

    // Error response frees m1; the held retry is granted the cycle after the response.
    e0 = mk_a(OPC_PUT_FULL, 3'd2, 2'd0, 10'h0AA, 32'h12345678);
    bus.m1_a_channel = e0;
    bus.m1_a_valid   = 1'b1;
    bus.s_a_ready    = 1'b1;
    exp_a.push_back(mk_a(OPC_PUT_FULL, 3'd2, 2'd1, 10'h0AA, 32'h12345678));
    exp_a.push_back(mk_a(OPC_PUT_FULL, 3'd2, 2'd1, 10'h0AA, 32'h12345678));
    wait_grant(1, 4, n);
    chk("t6_first_wait", n, 0);
    cyc();
    d = mk_d(OPC_ACK, 3'd2, 2'd1, 32'h0);
    bus.s_d_valid   = 1'b1;
    bus.s_d_error   = 1'b1;
    bus.s_d_channel = d;
    exp_d1.push_back('{ch: d, err: 1'b1});
    @(negedge clk);
    chk("t6_busy_no_grant", bus.m1_a_ready, 0);
    cyc();
    bus.s_d_valid = 1'b0;
    bus.s_d_error = 1'b0;
    @(negedge clk);
    chk("t6_m1_d_error", bus.m1_d_error, 1);
    chk("t6_retry_grant", bus.m1_a_ready, 1);
    cyc();
    bus.m1_a_valid = 1'b0;
    cyc();
    d = mk_d(OPC_ACK, 3'd2, 2'd1, 32'h0);
    bus.s_d_valid   = 1'b1;
    bus.s_d_channel = d;
    exp_d1.push_back('{ch: d, err: 1'b0});
    cyc();
    bus.s_d_valid = 1'b0;
    cyc();
    cyc();
    @(negedge clk);
    chk("end_protocol_err", bus.protocol_err, 0);
    chk("end_exp_a_empty", exp_a.size(), 0);
    chk("end_exp_d0_empty", exp_d0.size(), 0);
    chk("end_exp_d1_empty", exp_d1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
